breath_timer: RTL
=================

BREATH_TIMER -- requirements
Module: breath_timer

Interface
REQ-001 Parameter CLK_DIV, default 50, clock cycles per tick (1 us at 50 MHz); legal range 1..65535.
REQ-002 Parameter PERIOD, default 1000, ticks per PWM period; this is the pulse_cnt modulus; legal range 2..1024.
REQ-003 Parameter STEPS, default 1000, PWM periods per brightness ramp; this is the display_cnt modulus; legal range 2..1024.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run enable; low forces IDLE and clears all counters.
REQ-007 hold  input  1  freeze request; counters keep their values while asserted.
REQ-008 pulse_cnt  output  10  intra-period position, 0..PERIOD-1; drives the PWM comparator.
REQ-009 display_cnt  output  10  brightness step, 0..STEPS-1; drives the PWM duty threshold.
REQ-010 delay_1s  output  1  single-cycle strobe on display_cnt wrap; drives the PWM mode toggle.
REQ-011 running  output  1  high when the FSM is in RUN.

Function
REQ-012 FSM states SHALL be IDLE, RUN and HOLD.
REQ-013 Transitions SHALL be:
- IDLE->RUN when en=1.
- RUN->HOLD when en=1 and hold=1.
- HOLD->RUN when en=1 and hold=0.
- any state->IDLE when en=0; en=0 has priority over hold.
REQ-014 In IDLE, the prescaler, pulse_cnt and display_cnt SHALL be cleared to 0 on the next clock edge, and delay_1s SHALL be 0.
REQ-015 In RUN, the prescaler SHALL count 0..CLK_DIV-1 and wrap; tick is asserted internally in the cycle the prescaler equals CLK_DIV-1.
REQ-016 On tick, pulse_cnt SHALL increment and wrap PERIOD-1->0; the wrap generates an internal step.
REQ-017 On step, display_cnt SHALL increment and wrap STEPS-1->0.
REQ-018 delay_1s SHALL be registered and high for exactly one cycle: the first cycle in which display_cnt reads 0 after a wrap.
REQ-019 delay_1s SHALL NOT assert on the IDLE->RUN entry, nor after a clear.
REQ-020 With defaults, delay_1s period SHALL be CLK_DIV*PERIOD*STEPS = 50,000,000 cycles.
REQ-021 In HOLD, all counters SHALL retain their values and delay_1s SHALL be 0.
REQ-022 On HOLD->RUN, counting SHALL resume from the retained prescaler value, with no lost and no extra tick.
REQ-023 Hold asserted in the same cycle as a pending wrap SHALL suppress that wrap; it occurs after resume.
REQ-024 When CLK_DIV=1, tick SHALL assert every RUN cycle.
REQ-025 All outputs SHALL be driven directly from flops; there is no combinational path from inputs to outputs.
REQ-026 pulse_cnt and display_cnt SHALL zero-extend to 10 bits; values at or above the modulus SHALL never appear.

Reset
REQ-027 While rst_n=0, the following SHALL hold asynchronously:
- FSM=IDLE, prescaler=0, pulse_cnt=0, display_cnt=0.
- delay_1s=0, running=0.
REQ-028 Reset asserted mid-ramp SHALL clear all state immediately.
REQ-029 After rst_n deassertion with en=1, the first tick SHALL occur CLK_DIV cycles after entering RUN.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state enum;
- the counter width constant CNT_W=10;
- the default CLK_DIV, PERIOD and STEPS values.
REQ-031 One sub-module, mod_cnt, SHALL be used: a parameterised modulo counter with inc, clr and hold inputs, outputs value and wrap. It is instantiated three times (prescaler, pulse, display).
REQ-032 Illegal parameter values SHALL be rejected at elaboration.

Verification (bench parameters CLK_DIV=2, PERIOD=4, STEPS=3 unless noted)
REQ-033 Reset release, then en=1 -> first tick at cycle 2; pulse_cnt sequence 0,1,2,3,0; delay_1s high for one cycle every 24 cycles; display_cnt sequence 0,1,2,0.
REQ-034 hold=1 for 10 cycles mid-period -> counters frozen; running=0; delay_1s=0; after release, the next delay_1s arrives exactly 10 cycles later than it would have without the hold.
REQ-035 en=0 and hold=1 in the same cycle -> IDLE; all counters read 0 on the next cycle; no delay_1s pulse.
REQ-036 rst_n pulled low for 1 cycle at pulse_cnt=2, display_cnt=2 -> all outputs 0 asynchronously; counting restarts cleanly afterwards.
REQ-037 CLK_DIV=1, PERIOD=2, STEPS=2 -> delay_1s every 4 cycles; pulse_cnt toggles each cycle.
REQ-038 Defaults, run 100 ms of simulated time -> display_cnt=100, no delay_1s; the first delay_1s appears at 50,000,000 cycles.

Source files
------------

// File: rtl/breath_timer_pkg.sv
// Shared types and constants for the breathing-LED ramp timer.
package breath_timer_pkg;

    localparam int unsigned CNT_W           = 10;
    localparam int unsigned PRE_W           = 16;
    localparam int unsigned DEF_CLK_DIV     = 50;
    localparam int unsigned DEF_PERIOD      = 1000;
    localparam int unsigned DEF_STEPS       = 1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/mod_cnt.sv
// Modulo-MOD counter with synchronous clear and freeze; wrap flags the advancing terminal count.
module mod_cnt #(
    parameter int unsigned MOD = 2,
    parameter int unsigned W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic         hold,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MOD - 1);

    if (MOD < 1 || MOD > (2 ** W)) begin : g_bad_mod
        $error("mod_cnt: MOD out of range for width W");
    end

    // Terminal count reached while advancing.
    always_comb begin
        wrap = 1'b0;
        if (inc && !hold && (value == MAX_V)) begin
            wrap = 1'b1;
        end else begin
            wrap = 1'b0;
        end
    end

    // Counter register: clear beats hold, hold beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !hold) begin
            if (wrap) begin
                value <= '0;
            end else begin
                value <= value + {{(W-1){1'b0}}, 1'b1};
            end
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/breath_timer.sv
// Breathing-LED timebase: prescaler -> intra-period position -> brightness step, with hold/idle control.
module breath_timer
    import breath_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned PERIOD  = DEF_PERIOD,
    parameter int unsigned STEPS   = DEF_STEPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             hold,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [CNT_W-1:0] display_cnt,
    output logic             delay_1s,
    output logic             running
);

    if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("breath_timer: CLK_DIV must be 1..65535");
    end
    if (PERIOD < 2 || PERIOD > 1024) begin : g_bad_period
        $error("breath_timer: PERIOD must be 2..1024");
    end
    if (STEPS < 2 || STEPS > 1024) begin : g_bad_steps
        $error("breath_timer: STEPS must be 2..1024");
    end

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    state_e           state_r;
    state_e           state_s;
    logic             cnt_en_s;
    logic             clr_s;
    logic             pre_wrap_s;
    logic             tick_s;
    logic             step_s;
    logic             ramp_wrap_s;
    logic [PRE_W-1:0] pre_val_s;
    logic             delay_1s_r;
    logic             running_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state; en=0 dominates hold from every state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en) state_s = ST_RUN;
                else    state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!en)      state_s = ST_IDLE;
                else if (hold) state_s = ST_HOLD;
                else          state_s = ST_RUN;
            end
            ST_HOLD: begin
                if (!en)       state_s = ST_IDLE;
                else if (!hold) state_s = ST_RUN;
                else           state_s = ST_HOLD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Counting is gated by the live hold input so a freeze takes effect on the very edge
    // it is sampled and resumes without losing or adding a prescaler cycle.
    always_comb begin
        cnt_en_s = 1'b0;
        clr_s    = 1'b0;
        if (!en || (state_r == ST_IDLE)) begin
            clr_s    = 1'b1;
            cnt_en_s = 1'b0;
        end else begin
            clr_s    = 1'b0;
            cnt_en_s = 1'b1;
        end
    end

    assign tick_s = pre_wrap_s && (pre_val_s == PRE_MAX);

    mod_cnt #(.MOD(CLK_DIV), .W(PRE_W)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_en_s),
        .clr   (clr_s),
        .hold  (hold),
        .value (pre_val_s),
        .wrap  (pre_wrap_s)
    );

    mod_cnt #(.MOD(PERIOD), .W(CNT_W)) u_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tick_s),
        .clr   (clr_s),
        .hold  (hold),
        .value (pulse_cnt),
        .wrap  (step_s)
    );

    mod_cnt #(.MOD(STEPS), .W(CNT_W)) u_display (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (step_s),
        .clr   (clr_s),
        .hold  (hold),
        .value (display_cnt),
        .wrap  (ramp_wrap_s)
    );

    // Strobe lands in the same cycle display_cnt first reads 0 after a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_1s_r <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            delay_1s_r <= ramp_wrap_s;
            running_r  <= (state_s == ST_RUN);
        end
    end

    assign delay_1s = delay_1s_r;
    assign running  = running_r;

endmodule
